// File: rtl/hex_display_updater.sv
// Time-multiplexes one external seven-segment decoder across NUM_DIGITS hold
// registers, with leading-zero blanking and per-digit blinking on the outputs.
module hex_display_updater #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              dec_nibble,
  input  logic [6:0]              dec_seg,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    update_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic                    done_next;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    lz_flag;
  logic [6:0]              hold [NUM_DIGITS];
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic                    accept;
  logic                    last_digit;
  logic                    upper_zero;
  logic                    blank_this;
  logic [6:0]              seg_write;

  assign load_ready = (state == IDLE);
  assign accept     = load_valid && load_ready;
  assign last_digit = (idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  // NOTE: every flop is written with <= so all registers update from the
  // pre-edge values; blocking = here would make ordering change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      update_done <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      update_done <= done_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = UPDATE;
          idx_next   = '0;
        end
      end
      UPDATE: begin
        if (last_digit) begin
          state_next = IDLE;
          idx_next   = '0;
          done_next  = 1'b1;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      lz_flag <= 1'b0;
    end else if (accept) begin
      shadow  <= load_value;
      lz_flag <= lz_en;
    end
  end

  // Nibble mux to the shared decoder; shadow is zero in reset so this is too.
  always_comb begin
    dec_nibble = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) dec_nibble = shadow[4*i +: 4];
    end
  end

  // Leading-zero test: current digit and everything above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (shadow[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end

  assign blank_this = lz_flag && (idx != '0) && upper_zero;
  assign seg_write  = blank_this ? SEG_BLANK : dec_seg;

  // ---------------------------------------------------------------------------
  // Per-digit hold registers
  // ---------------------------------------------------------------------------
  // NOTE: the hold array is a bank of flops, not RAM, so it is reset to blank
  // to keep the display dark until the first update completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) hold[i] <= SEG_BLANK;
    end else if (state == UPDATE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) hold[i] <= seg_write;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running blink timebase
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Blinking masks the held pattern only; hold contents are untouched.
  always_comb begin
    hex_out = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_out[7*i +: 7] = (blink_mask[i] && blink_phase) ? SEG_BLANK : hold[i];
    end
  end

endmodule

// File: tb/tb_hex_display_updater.sv
// Randomized self-checking bench for hex_display_updater with a model of the
// external decoder and a digit-level reference of the expected display.
module tb_hex_display_updater;

  localparam int ND = 6;
  localparam int BD = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [4*ND-1:0] load_value = '0;
  logic            lz_en = 1'b0;
  logic [ND-1:0]   blink_mask = '0;
  logic [3:0]      dec_nibble;
  logic [6:0]      dec_seg;
  logic [7*ND-1:0] hex_out;
  logic            update_done;

  int tests = 0;
  int fails = 0;
  int edges;
  logic [6:0] exp_hold [ND];

  hex_display_updater #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .lz_en       (lz_en),
    .blink_mask  (blink_mask),
    .dec_nibble  (dec_nibble),
    .dec_seg     (dec_seg),
    .hex_out     (hex_out),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  // Active-low seven-segment decoder, bit0 = segment a.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign dec_seg = seg_of(dec_nibble);

  // Edges since reset release; the blink phase follows from this alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic logic [3:0] nib(input logic [4*ND-1:0] v, input int i);
    return 4'((v >> (4*i)) & 'hF);
  endfunction

  // Displayed pattern for digit i: blanked if lz and it lies above the most
  // significant nonzero digit; digit 0 always shows.
  function automatic logic [6:0] model_digit(input logic [4*ND-1:0] v, input logic lz, input int i);
    int msd = -1;
    for (int k = 0; k < ND; k++) if (nib(v, k) != 0) msd = k;
    if (lz && i > 0 && i > msd) return 7'h7F;
    return seg_of(nib(v, i));
  endfunction

  function automatic logic [7*ND-1:0] exp_hex();
    logic [7*ND-1:0] r = '0;
    logic phase = ((edges / BD) % 2) == 1;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = (blink_mask[i] && phase) ? 7'h7F : exp_hold[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) exp_hold[i] = 7'h7F;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_hex"},   64'(hex_out), 64'(exp_hex()));
    check({tag, "_ready"}, 64'(load_ready), 64'd1);
    check({tag, "_done"},  64'(update_done), 64'd0);
    check({tag, "_nib"},   64'(dec_nibble), 64'd0);
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic start_load(input logic [4*ND-1:0] v, input logic lz);
    int waited = 0;
    load_value = v;
    lz_en      = lz;
    load_valid = 1'b1;
    while (!load_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!load_ready) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  // Checks the negedge after the accept edge and after each of ND more edges.
  task automatic track_update(input logic [4*ND-1:0] v, input logic lz);
    for (int k = 0; k <= ND; k++) begin
      if (k > 0) exp_hold[k-1] = model_digit(v, lz, k-1);
      @(negedge clk);
      check($sformatf("upd_ready_k%0d", k), 64'(load_ready),  64'(k == ND));
      check($sformatf("upd_done_k%0d", k),  64'(update_done), 64'(k == ND));
      check($sformatf("upd_nib_k%0d", k),   64'(dec_nibble),  64'(nib(v, k % ND)));
      check($sformatf("upd_hex_k%0d", k),   64'(hex_out),     64'(exp_hex()));
    end
  endtask

  task automatic full_load(input logic [4*ND-1:0] v, input logic lz);
    start_load(v, lz);
    track_update(v, lz);
  endtask

  initial begin
    logic [4*ND-1:0] v;
    logic            lz;
    int              keep;

    model_reset();
    repeat (3) @(negedge clk);
    check_idle_reset("rst_low");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset("rst_rel");

    // Directed: no blanking, then blanking, then all-zero.
    full_load(24'h00A05F, 1'b0);
    @(negedge clk);
    check("done_pulse_end", 64'(update_done), 64'd0);
    check("d_plain_hex", 64'(hex_out), 64'(exp_hex()));
    full_load(24'h00A05F, 1'b1);
    check("d_lz_d5", 64'(hex_out[41:35]), 64'h7F);
    check("d_lz_d2", 64'(hex_out[20:14]), 64'h40);
    full_load(24'h000000, 1'b1);
    check("d_zero_d0", 64'(hex_out[6:0]), 64'h40);
    check("d_zero_hi", 64'(hex_out[41:7]), 64'h7_FFFF_FFFF);

    // Blink on digit 0 only.
    full_load(24'h00A05F, 1'b0);
    blink_mask = 6'b000001;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("blink_hex", 64'(hex_out), 64'(exp_hex()));
      check("blink_d0", 64'(hex_out[6:0]), (((edges / BD) % 2) == 1) ? 64'h7F : 64'h0E);
    end
    blink_mask = '0;

    // Request held through an active update is taken right after it finishes.
    @(negedge clk);
    start_load(24'hFEDCBA, 1'b0);
    load_value = 24'h123456;
    lz_en      = 1'b0;
    load_valid = 1'b1;
    track_update(24'hFEDCBA, 1'b0);
    start_load(24'h123456, 1'b0);
    track_update(24'h123456, 1'b0);
    check("b2b_d0", 64'(hex_out[6:0]), 64'h02);

    // Randomized loads with random leading-zero depth, lz and blink mask.
    for (int t = 0; t < 10; t++) begin
      v    = 24'($urandom);
      keep = $urandom_range(0, ND);
      if (keep < ND) v = v & ((24'd1 << (4*keep)) - 24'd1);
      lz         = 1'($urandom);
      blink_mask = 6'($urandom);
      full_load(v, lz);
    end
    blink_mask = '0;

    // Reset mid-update while idx == 3: everything back to blank and idle.
    @(negedge clk);
    start_load(24'h987654, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_nib", 64'(dec_nibble), 64'h7);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_idle_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < ND + 2; c++) begin
      @(negedge clk);
      check("post_abort_done", 64'(update_done), 64'd0);
      check("post_abort_hex",  64'(hex_out), 64'(exp_hex()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_display_updater.md
Name: hex_display_updater

Overview:
- Sequences one shared seven-segment decoder across NUM_DIGITS display digits (HEX0..HEX5 on the DE10-Lite).
- A requester hands over a packed hex value with a valid/ready handshake. The block then walks the digits one per clock, drives each nibble into the external decoder, and latches the returned segment pattern into a per-digit hold register.
- Also does optional leading-zero blanking and per-digit blinking. Sits between the application logic and the HEX pins.

Parameters:
- NUM_DIGITS, 6, number of digits / hold registers (>=2).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  requester presents load_value/lz_en
- load_ready  output  1  block can accept a load
- load_value  input  4*NUM_DIGITS  packed nibbles, [3:0] = digit 0 (rightmost)
- lz_en  input  1  leading-zero blanking for this load
- blink_mask  input  NUM_DIGITS  live per-digit blink enable
- dec_nibble  output  4  nibble to the shared decoder
- dec_seg  input  7  decoder result, combinational from dec_nibble, active-low, bit0 = segment a
- hex_out  output  7*NUM_DIGITS  segment patterns, [6:0] = digit 0, active-low
- update_done  output  1  one-cycle pulse after the last digit is written

Behaviour:
- One clock: clk. Reset: rst_n, asynchronous, active-low.
- Reset values:
  - state IDLE, idx 0, shadow value 0, lz flag 0.
  - All hold registers 7'h7F (blank).
  - Blink counter 0, blink phase 0.
  - update_done 0, load_ready 1.
- dec_nibble = shadow[idx] combinationally; equals 0 while in reset.
- FSM has two states, IDLE and UPDATE. load_ready = (state == IDLE).
- IDLE:
  - On the edge where load_valid && load_ready: capture load_value into shadow and lz_en into the lz flag.
  - Set idx = 0 and go to UPDATE.
  - load_value and lz_en are ignored after the capture edge.
- UPDATE, each edge:
  - Write hold[idx] = blank_this ? 7'h7F : dec_seg.
  - If idx == NUM_DIGITS-1: go to IDLE, set update_done = 1 for exactly one cycle, idx = 0.
  - Otherwise idx = idx + 1.
- blank_this = lz flag && idx != 0 && every shadow nibble at position >= idx is zero. Digit 0 is never blanked by leading-zero blanking.
- Latency: if the accept is at edge E0, digit i is written at edge E(i+1).
  - update_done and load_ready are both high in the cycle after edge E(NUM_DIGITS).
  - A new load is accepted at that edge at the earliest.
  - Throughput: one load per NUM_DIGITS+1 cycles.
- Hold registers not yet rewritten keep their previous pattern during UPDATE. There is no intermediate blanking.
- load_valid during UPDATE is ignored. The requester holds valid and data until it sees ready; the block never drops an accepted request.
- Blink counter:
  - Free-running 0..BLINK_DIV-1, independent of the FSM.
  - On wrap, the phase toggles.
- hex_out digit i is combinational: (blink_mask[i] && phase) ? 7'h7F : hold[i].
- Asserting rst_n low mid-update aborts immediately. All outputs return to reset values; partial writes are lost (digits blank).
- Counter widths are sized with $clog2 from the parameters. idx never exceeds NUM_DIGITS-1.

Test Plan (NUM_DIGITS=6, BLINK_DIV=4, blink_mask=0 unless stated):
- Reset pulse -> hex_out = 42'h3FFFFFFFFFF (all digits 7'h7F); load_ready=1; update_done=0; dec_nibble=0.
- Load 24'h00A05F, lz_en=0, accept at E0 -> after E6:
  - digit0..5 = 7'h0E, 7'h12, 7'h40, 7'h08, 7'h40, 7'h40.
  - update_done high exactly one cycle after E6.
  - load_ready low from E0 through E6.
- Same value with lz_en=1 -> digits 4 and 5 = 7'h7F; digit2 = 7'h40 (zero with a nonzero digit above); digits 0, 1, 3 as in the previous scenario.
- Load 24'h000000 with lz_en=1 -> digit0 = 7'h40, digits 1..5 = 7'h7F.
- After the 00A05F load, set blink_mask=6'b000001 -> digit0 alternates 7'h0E / 7'h7F every 4 cycles; digits 1..5 stay steady.
- Handshake and reset:
  - Hold load_valid high with 24'h123456 during an update -> it is accepted at the edge after the update_done cycle begins and finishes with digit0 = 7'h02.
  - Drop rst_n low while idx==3 -> all digits 7'h7F, FSM in IDLE, load_ready=1, with no update_done pulse.
